// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Instruction-fetch controller between a word-addressed instruction memory
//   with a 1-cycle registered read and the decode stage.
//   Owns the PC, issues fetch addresses, absorbs the read latency and
//   delivers instructions over a valid/ready handshake. It also handles
//   start/halt control, branch/jump redirects and PC wrap-around.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse: IDLE/HALTED -> RUN
//   halt_req          pulse: stop issuing, drain outstanding words, -> HALTED
//   redirect_valid    pulse: flush all fetches, continue at redirect_pc
//   redirect_pc       redirect target
//   imem_pc           memory address (registered)
//   imem_rdata        memory data, valid the cycle after the address
//   instr_valid       instr/instr_pc hold a valid instruction
//   instr_ready       decode accepts (fire = instr_valid & instr_ready)
//   instr, instr_pc   fetched instruction and its address
//   busy              state is RUN or DRAIN
//   halted            state is HALTED
//   addr_err          sticky out-of-range redirect flag
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_DEPTH = 1000,
  parameter int unsigned START_PC  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_pc,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              busy,
  output logic              halted,
  output logic              addr_err
);

  localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(START_PC);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_e;

  state_e              state_q, state_d;

  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                inflight_q, inflight_d;
  logic [ADDR_W-1:0]   inflight_pc_q, inflight_pc_d;

  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_pc_q, out_pc_d;

  logic                skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [ADDR_W-1:0]   skid_pc_q, skid_pc_d;

  logic                addr_err_q, addr_err_d;

  logic                fire;
  logic [1:0]          occ;
  logic [1:0]          occ_after_fire;
  logic                redir_oor;
  logic                issue;
  logic [ADDR_W-1:0]   pc_inc;

  // Handshake / occupancy bookkeeping shared by the FSM and the datapath.
  always_comb begin
    fire           = out_valid_q & instr_ready;
    occ            = {1'b0, inflight_q} + {1'b0, out_valid_q} + {1'b0, skid_valid_q};
    occ_after_fire = occ - {1'b0, fire};
    redir_oor      = redirect_valid & (redirect_pc > LAST_PC);
    // halt_req stops issue in the very cycle it is seen; a redirect cycle
    // only loads the pc, so issue resumes on the following cycle.
    issue          = (state_q == ST_RUN) & ~halt_req & ~redirect_valid &
                     (occ_after_fire < 2'd2);
    pc_inc         = (pc_q == LAST_PC) ? '0 : pc_q + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_pc_q      <= '0;
      skid_valid_q  <= 1'b0;
      skid_data_q   <= '0;
      skid_pc_q     <= '0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_pc_q      <= out_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_data_q   <= skid_data_d;
      skid_pc_q     <= skid_pc_d;
      addr_err_q    <= addr_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (halt_req) begin
          // A redirect in the same cycle flushes everything, so there is
          // nothing left to drain.
          state_d = redirect_valid ? ST_HALTED : ST_DRAIN;
        end
      end
      ST_DRAIN:  if (occ == 2'd0) state_d = ST_HALTED;
      ST_HALTED: if (start) state_d = ST_RUN;
      default:   state_d = ST_IDLE;
    endcase
    if (redir_oor) state_d = ST_HALTED;
  end

  // ---------------------------------------------------------------------------
  // Datapath next values: pc, in-flight tracking, output register, skid buffer
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_pc_d      = out_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_data_d   = skid_data_q;
    skid_pc_d     = skid_pc_q;
    addr_err_d    = addr_err_q | redir_oor;

    if (redirect_valid) begin
      // Flush every stage; only an in-range target updates the pc.
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      if (!redir_oor) pc_d = redirect_pc;
    end else begin
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_inc;
      end

      if (out_valid_q && !fire) begin
        // Output stalled: hold it, park a returning word in the skid buffer.
        if (inflight_q) begin
          skid_valid_d = 1'b1;
          skid_data_d  = imem_rdata;
          skid_pc_d    = inflight_pc_q;
        end
      end else if (skid_valid_q) begin
        // Output firing with a parked word: the older skid entry moves up
        // first, a word returning now takes its place in the skid buffer.
        out_valid_d = 1'b1;
        out_data_d  = skid_data_q;
        out_pc_d    = skid_pc_q;
        if (inflight_q) begin
          skid_valid_d = 1'b1;
          skid_data_d  = imem_rdata;
          skid_pc_d    = inflight_pc_q;
        end else begin
          skid_valid_d = 1'b0;
        end
      end else if (inflight_q) begin
        out_valid_d = 1'b1;
        out_data_d  = imem_rdata;
        out_pc_d    = inflight_pc_q;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_pc     = pc_q;
    instr_valid = out_valid_q;
    instr       = out_data_q;
    instr_pc    = out_pc_q;
    busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    halted      = (state_q == ST_HALTED);
    addr_err    = addr_err_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          halt_req;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] imem_pc;
  logic [DW-1:0] imem_rdata;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          busy;
  logic          halted;
  logic          addr_err;

  fetch_sequencer #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MEM_DEPTH(DEPTH),
    .START_PC (0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .halt_req      (halt_req),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_pc       (imem_pc),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .busy          (busy),
    .halted        (halted),
    .addr_err      (addr_err)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed function of the address.
  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    logic [31:0] x;
    x = {22'h0, a};
    return (x * 32'h9E3779B1) ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) imem_rdata <= memf(imem_pc);

  int tests = 0;
  int fails = 0;
  int deliv = 0;

  // Reference: the pc the decoder must receive next (program-order stream).
  int exp_q[$];
  bit chk_en    = 1'b1;
  bit flush_evt = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: compares every accepted instruction against the reference stream
  // and checks that a stalled output holds still.
  bit            prev_stall = 1'b0;
  logic [AW-1:0] prev_pc;
  logic [DW-1:0] prev_instr;

  always @(negedge clk) begin
    int p;
    if (!rst_n) begin
      prev_stall = 1'b0;
      flush_evt  = 1'b0;
    end else begin
      if (prev_stall && !flush_evt && chk_en) begin
        chk("stall_valid", instr_valid, 1);
        chk("stall_pc", instr_pc, prev_pc);
        chk("stall_instr", instr, prev_instr);
      end
      flush_evt  = 1'b0;
      prev_stall = instr_valid && !instr_ready;
      prev_pc    = instr_pc;
      prev_instr = instr;
      if (instr_valid && instr_ready) begin
        deliv++;
        if (chk_en) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_instr: got pc %0d expected none", instr_pc);
          end else begin
            p = exp_q.pop_front();
            chk("instr_pc", instr_pc, p);
            chk("instr", instr, memf(AW'(p)));
            exp_q.push_back((p == DEPTH - 1) ? 0 : p + 1);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input int r);
    redirect_valid = 1'b1;
    redirect_pc    = AW'(r);
    @(posedge clk);
    exp_q.delete();
    if (r < DEPTH) exp_q.push_back(r);
    flush_evt = 1'b1;
    #1;
    redirect_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_imem_pc"}, imem_pc, 0);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_instr_pc"}, instr_pc, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_addr_err"}, addr_err, 0);
  endtask

  initial begin
    int d0, dh;
    logic [AW-1:0] ip;
    logic [AW-1:0] wrap_exp [4];
    bit got;

    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(0);
    step();
    check_reset_vals("reset");

    // 1: start, ready high, back-to-back delivery from pc 0.
    start = 1'b1; instr_ready = 1'b1;
    step();
    start = 1'b0;
    chk("t1_busy", busy, 1);
    step();
    chk("t1_lat_valid_early", instr_valid, 0);
    step();
    chk("t1_lat_valid", instr_valid, 1);
    chk("t1_first_pc", instr_pc, 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("t1_no_bubble", instr_valid, 1);
      chk("t1_seq_pc", instr_pc, i);
    end

    // 2: stall for 4 cycles; fetch address freezes with 2 outstanding.
    instr_ready = 1'b0;
    step(); step();
    ip = imem_pc;
    step(); step();
    chk("t2_imem_pc_frozen", imem_pc, ip);
    chk("t2_stall_pc", instr_pc, exp_q[0]);
    instr_ready = 1'b1;
    repeat (6) step();

    // 3: redirect to 10 mid-stream.
    do_redirect(10);
    chk("t3_flush_valid", instr_valid, 0);
    step();
    chk("t3_gap_valid", instr_valid, 0);
    step();
    chk("t3_new_valid", instr_valid, 1);
    chk("t3_new_pc", instr_pc, 10);
    repeat (3) step();

    // 4: wrap-around from the top of memory.
    wrap_exp[0] = 10'd998; wrap_exp[1] = 10'd999; wrap_exp[2] = 10'd0; wrap_exp[3] = 10'd1;
    do_redirect(998);
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_wrap_pc", instr_pc, wrap_exp[i]);
      chk("t4_wrap_valid", instr_valid, 1);
    end

    // 5: halt with 2 words outstanding.
    instr_ready = 1'b0;
    repeat (3) step();
    dh = deliv;
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("t5_drain_busy", busy, 1);
    instr_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (halted) got = 1'b1;
    end
    chk("t5_halted", halted, 1);
    chk("t5_drained_two", deliv - dh, 2);
    d0 = deliv; ip = imem_pc;
    repeat (6) step();
    chk("t5_no_issue_pc", imem_pc, ip);
    chk("t5_no_output", deliv - d0, 0);
    chk("t5_busy_low", busy, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_resume_busy", busy, 1);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (instr_valid) got = 1'b1;
    end
    chk("t5_resume_valid", got, 1);

    // Randomised traffic: ready patterns, redirects, halts, restarts.
    d0 = deliv;
    for (int c = 0; c < 3000; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      start       = ($urandom_range(0, 9) == 0);
      halt_req    = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 59) == 0) begin
        if ($urandom_range(0, 1) == 0) do_redirect($urandom_range(994, 999));
        else do_redirect($urandom_range(0, 999));
      end else begin
        step();
      end
    end
    start = 1'b0; halt_req = 1'b0; instr_ready = 1'b1;
    repeat (10) step();
    tests++;
    if (deliv - d0 < 500) begin
      fails++;
      $display("FAIL rand_progress: got %0d deliveries expected at least 500", deliv - d0);
    end

    // 6: out-of-range redirect, then asynchronous reset mid-stream.
    if (!busy) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    repeat (4) step();
    do_redirect(1000);
    chk_en = 1'b0;
    chk("t6_addr_err", addr_err, 1);
    chk("t6_halted", halted, 1);
    chk("t6_valid", instr_valid, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    chk("t6_addr_err_sticky", addr_err, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6_async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(0);
    chk_en = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (instr_valid) got = 1'b1;
    end
    chk("t6_restart_valid", got, 1);
    chk("t6_restart_pc", instr_pc, 0);
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
